// File: rtl/red_pitaya_asg_slew.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_slew
//
// Output conditioning stage between one ASG channel and the DAC mux. It limits
// the per-cycle change of the DAC sample. It soft-starts from 0 when the
// channel is enabled and soft-stops back to 0 when it is disabled. This keeps
// full-scale steps out of the analog path, whether they come from a waveform
// wrap, a trigger restart or on/off switching.
//
// Optional feature macro:
//   ASG_SLEW_CNT_EN  - when defined, cnt_o counts the cycles in which the
//                      output update was clamped. The count saturates at
//                      all-ones and is cleared by cnt_clr_i. When the macro is
//                      undefined, cnt_o is tied to 0 and cnt_clr_i is ignored.
//
// Ports:
//   dac_clk_i    in   1      DAC clock, the only clock
//   dac_rstn_i   in   1      asynchronous active-low reset
//   dat_i        in   DW     signed sample from ASG channel, valid every cycle
//   set_en_i     in   1      1 = ramp up / track, 0 = ramp down and stay off
//   set_slew_i   in   DW-1   max |step| per cycle while tracking, 0 = bypass
//   set_ramp_i   in   DW-1   max |step| per cycle while ramping, 0 = one cycle
//   cnt_clr_i    in   1      synchronous clear of the limit counter
//   dac_o        out  DW     signed conditioned sample to DAC
//   limit_o      out  1      this cycle's dac_o update was clamped
//   state_o      out  2      0 OFF, 1 RAMP_UP, 2 TRACK, 3 RAMP_DN
//   done_o       out  1      one-cycle pulse on RAMP_DN -> OFF
//   cnt_o        out  CNT_W  clamped-cycle count
// -----------------------------------------------------------------------------
module red_pitaya_asg_slew #(
    parameter int unsigned DW    = 14,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rstn_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 set_en_i,
    input  logic        [DW-2:0] set_slew_i,
    input  logic        [DW-2:0] set_ramp_i,
    input  logic                 cnt_clr_i,
    output logic signed [DW-1:0] dac_o,
    output logic                 limit_o,
    output logic        [1:0]    state_o,
    output logic                 done_o,
    output logic     [CNT_W-1:0] cnt_o
);

    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StRampUp = 2'd1,
        StTrack  = 2'd2,
        StRampDn = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic signed [DW-1:0] dat_r;
    logic signed [DW-1:0] dac_q, dac_d;
    logic                 limit_q, limit_d;
    logic                 done_q, done_d;

    // Update-rule operands, selected by the current (old) state.
    logic signed [DW-1:0] tgt;
    logic        [DW-2:0] step;
    logic        [DW:0]   step_x;
    logic signed [DW:0]   diff;
    logic        [DW:0]   diff_abs;
    logic        [DW:0]   sum;

    // -------------------------------------------------------------------------
    // Slew-limited update of dac toward tgt
    // -------------------------------------------------------------------------
    always_comb begin
        tgt = '0;
        step = '0;
        unique case (state_q)
            StOff: begin
                // Target 0 with an unlimited step keeps dac held at 0.
                tgt  = '0;
                step = '0;
            end
            StRampUp: begin
                tgt  = dat_r;
                step = set_ramp_i;
            end
            StTrack: begin
                tgt  = dat_r;
                step = set_slew_i;
            end
            StRampDn: begin
                tgt  = '0;
                step = set_ramp_i;
            end
        endcase

        // One extra bit so that full-scale differences cannot overflow.
        diff     = {tgt[DW-1], tgt} - {dac_q[DW-1], dac_q};
        diff_abs = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
        step_x   = {2'b00, step};
        sum      = '0;

        if (step == '0 || diff_abs <= step_x) begin
            dac_d   = tgt;
            limit_d = 1'b0;
        end else begin
            // The result lies strictly between dac_q and tgt, so it fits in DW.
            if (diff[DW]) begin
                sum = {dac_q[DW-1], dac_q} - step_x;
            end else begin
                sum = {dac_q[DW-1], dac_q} + step_x;
            end
            dac_d   = sum[DW-1:0];
            limit_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state; the enable input takes priority over arrival checks
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StOff: begin
                if (set_en_i) begin
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (!set_en_i) begin
                    state_d = StRampDn;
                end else if (!limit_d) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (!set_en_i) begin
                    state_d = StRampDn;
                end
            end
            StRampDn: begin
                if (set_en_i) begin
                    state_d = StRampUp;
                end else if (dac_d == '0) begin
                    state_d = StOff;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q <= StOff;
            dat_r   <= '0;
            dac_q   <= '0;
            limit_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_r   <= dat_i;
            dac_q   <= dac_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    assign dac_o   = dac_q;
    assign limit_o = limit_q;
    assign state_o = state_q;
    assign done_o  = done_q;

    // -------------------------------------------------------------------------
    // Optional clamp-event counter
    // -------------------------------------------------------------------------
`ifdef ASG_SLEW_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts on the same edge that registers limit_o; clear wins.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (limit_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_asg_slew.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_asg_slew
//
// Self-checking bench for red_pitaya_asg_slew. An integer reference model of
// the slew/ramp rules is stepped once per clock edge. Every cycle, all outputs
// are compared against the model. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_red_pitaya_asg_slew;

    localparam int DW    = 14;
    localparam int CNT_W = 32;

    typedef logic signed [DW-1:0] dat_t;
    typedef logic        [DW-2:0] set_t;

    logic              clk = 1'b0;
    logic              rstn;
    dat_t              dat;
    logic              en;
    set_t              slew;
    set_t              ramp;
    logic              clr;
    dat_t              dac;
    logic              limit;
    logic [1:0]        state;
    logic              done;
    logic [CNT_W-1:0]  cnt;

    always #5 clk = ~clk;

    red_pitaya_asg_slew #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) dut (
        .dac_clk_i  (clk),
        .dac_rstn_i (rstn),
        .dat_i      (dat),
        .set_en_i   (en),
        .set_slew_i (slew),
        .set_ramp_i (ramp),
        .cnt_clr_i  (clr),
        .dac_o      (dac),
        .limit_o    (limit),
        .state_o    (state),
        .done_o     (done),
        .cnt_o      (cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers)
    int     m_dat_r;
    int     m_dac;
    int     m_state;
    bit     m_lim;
    bit     m_done;
    longint m_cnt;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dat_r = 0;
        m_dac   = 0;
        m_state = 0;
        m_lim   = 0;
        m_done  = 0;
        m_cnt   = 0;
    endtask

    // Applies one clock edge using the inputs present before the edge.
    task automatic model_step();
        int t;
        int s;
        int d;
        int nxt;
        int ns;
        bit lim;
        bit dn;
        if (!rstn) begin
            model_reset();
            return;
        end
        t = (m_state == 1 || m_state == 2) ? m_dat_r : 0;
        s = (m_state == 0) ? 0 : (m_state == 2) ? int'(slew) : int'(ramp);
        d = t - m_dac;
        if (s == 0 || (d < 0 ? -d : d) <= s) begin
            nxt = t;
            lim = 0;
        end else begin
            nxt = (d > 0) ? m_dac + s : m_dac - s;
            lim = 1;
        end
        ns = m_state;
        dn = 0;
        case (m_state)
            0: if (en) ns = 1;
            1: if (!en) ns = 3; else if (nxt == t) ns = 2;
            2: if (!en) ns = 3;
            default: begin
                if (en) ns = 1;
                else if (nxt == 0) begin
                    ns = 0;
                    dn = 1;
                end
            end
        endcase
`ifdef ASG_SLEW_CNT_EN
        if (clr) m_cnt = 0;
        else if (lim && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
`else
        m_cnt = 0;
`endif
        m_dat_r = int'(dat);
        m_dac   = nxt;
        m_lim   = lim;
        m_state = ns;
        m_done  = dn;
    endtask

    task automatic compare_all();
        check("dac_o", dac, m_dac);
        check("limit_o", limit, m_lim);
        check("state_o", state, m_state);
        check("done_o", done, m_done);
        check("cnt_o", cnt, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        rstn = 1'b1;
    endtask

    function automatic set_t pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return set_t'($urandom_range(1, 8));
            2:       return set_t'($urandom_range(1, 300));
            default: return set_t'($urandom);
        endcase
    endfunction

    initial begin
        rstn = 1'b1;
        dat  = dat_t'(14'h1FFF);
        en   = 1'b1;
        slew = '0;
        ramp = '0;
        clr  = 1'b0;
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rstn = 1'b0;
        #1;
        check("rst_dac", dac, 0);
        check("rst_state", state, 0);
        check("rst_limit", limit, 0);
        check("rst_done", done, 0);
        repeat (3) step();

        // Soft start: OFF held with en=0, then 100,200..1000
        en   = 1'b0;
        dat  = 1000;
        ramp = 100;
        slew = 0;
        rstn = 1'b1;
        repeat (3) step();
        en = 1'b1;
        step();
        check("ss_enter", state, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("ss_dac", dac, 100 * k);
            check("ss_lim", limit, (k < 10));
        end
        check("ss_track", state, 2);
`ifdef ASG_SLEW_CNT_EN
        check("ss_cnt", cnt, 9);
`else
        check("ss_cnt", cnt, 0);
`endif

        // Slew clamp down to full negative scale
        slew = 50;
        dat  = 0;
        repeat (25) step();
        dat = -8192;
        repeat (170) step();
        check("slew_end", dac, -8192);
        check("slew_lim", limit, 0);

        // Bypass: two-cycle latency, no clamping
        slew = 0;
        dat  = 5;
        step();
        dat = -8192;
        step();
        check("bp_5", dac, 5);
        dat = 8191;
        step();
        check("bp_min", dac, -8192);
        step();
        check("bp_max", dac, 8191);
        check("bp_lim", limit, 0);

        // Soft stop from 800 with ramp 300
        dat = 800;
        repeat (3) step();
        check("stop_pre", dac, 800);
        ramp = 300;
        en   = 1'b0;
        step();
        check("stop_rd", state, 3);
        step();
        check("stop_500", dac, 500);
        step();
        check("stop_200", dac, 200);
        step();
        check("stop_0", dac, 0);
        check("stop_done", done, 1);
        check("stop_off", state, 0);
        step();
        check("stop_done_clr", done, 0);

        // Reversal during ramp down
        en = 1'b1;
        repeat (4) step();
        check("rev_up", dac, 800);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check("rev_500", dac, 500);
        check("rev_state", state, 1);
        step();
        check("rev_800", dac, 800);

        // Counter clear coincident with clamping
        en = 1'b0;
        repeat (6) step();
        ramp = 100;
        clr  = 1'b1;
        en   = 1'b1;
        repeat (5) step();
        check("clr_cnt", cnt, 0);
        check("clr_lim", limit, 1);
        clr = 1'b0;

        // en toggling every cycle
        for (int i = 0; i < 200; i++) begin
            en  = ~en;
            dat = dat_t'($urandom);
            if (i % 50 == 0) ramp = set_t'($urandom_range(1, 40));
            step();
        end

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) dat = dat_t'($urandom);
            if ($urandom_range(0, 31) == 0) slew = pick();
            if ($urandom_range(0, 31) == 0) ramp = pick();
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
